riscv32_mdu_ctrl: RTL



---
 rtl/riscv32_mdu_ctrl_pkg.sv | 39 +++
 rtl/riscv32_mdu_ctrl_if.sv | 32 +++
 rtl/riscv32_div_step.sv | 30 +++
 rtl/riscv32_mdu_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv32_mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv32_mdu_ctrl_pkg
// Shared definitions for the RV32 M-extension unit.
// Contents:
//   - EXE_FUN_LEN and exe_fun_t: the width and type of the execute function code.
//   - ALU_MUL..ALU_REMU: the eight M-extension operation codes.
//   - Decode helpers: is_mul, is_div, is_signed_div, is_rem.
// -----------------------------------------------------------------------------
package riscv32_mdu_ctrl_pkg;

  localparam int EXE_FUN_LEN = 5;
  typedef logic [EXE_FUN_LEN-1:0] exe_fun_t;

  localparam exe_fun_t ALU_MUL    = 5'd10;
  localparam exe_fun_t ALU_MULH   = 5'd11;
  localparam exe_fun_t ALU_MULHSU = 5'd12;
  localparam exe_fun_t ALU_MULHU  = 5'd13;
  localparam exe_fun_t ALU_DIV    = 5'd14;
  localparam exe_fun_t ALU_DIVU   = 5'd15;
  localparam exe_fun_t ALU_REM    = 5'd16;
  localparam exe_fun_t ALU_REMU   = 5'd17;

  function automatic logic is_mul(input exe_fun_t f);
    return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div(input exe_fun_t f);
    return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div(input exe_fun_t f);
    return f inside {ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_rem(input exe_fun_t f);
    return f inside {ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/riscv32_mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// riscv32_mdu_ctrl_if
// Request/response handshake between the EX stage and the M-extension unit.
// Signals:
//   - Request:  req_valid, req_ready, req_fun, req_op1, req_op2.
//   - Response: resp_valid, resp_ready, resp_data.
// Modports:
//   - master: the issuing pipeline stage.
//   - slave:  the MDU.
// -----------------------------------------------------------------------------
interface riscv32_mdu_ctrl_if;
  import riscv32_mdu_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  exe_fun_t    req_fun;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_fun, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_fun, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/riscv32_div_step.sv
// -----------------------------------------------------------------------------
// riscv32_div_step
// One combinational restoring-division step for unsigned 32-bit magnitudes.
// Ports:
//   - rem_i, quo_i, dvs_i: partial remainder, dividend/quotient shift register,
//     and divisor.
//   - rem_o, quo_o: remainder and quotient after this step.
// -----------------------------------------------------------------------------
module riscv32_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, dvs_i};
    // An unsigned compare rather than the borrow bit keeps divide-by-zero
    // well defined: the quotient becomes all ones and the remainder becomes
    // the dividend.
    ge      = (shifted >= {1'b0, dvs_i});
    rem_o   = ge ? diff[31:0] : shifted[31:0];
    quo_o   = {quo_i[30:0], ge};
  end
endmodule

// File: rtl/riscv32_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// riscv32_mdu_ctrl
// Multi-cycle RV32 M-extension unit with a registered multiplier and a
// 32-step radix-2 restoring divider.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - flush: synchronous kill of any in-flight operation.
//   - busy: high in every state except IDLE.
//   - bus: the request/response handshake (slave side).
// Parameters:
//   - MUL_LAT: number of cycles spent in MUL.
//   - ZERO_FASTPATH: divide-by-zero and signed overflow complete in one cycle.
// -----------------------------------------------------------------------------
module riscv32_mdu_ctrl
  import riscv32_mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT       = 2,
  parameter bit ZERO_FASTPATH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  riscv32_mdu_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  exe_fun_t    fun_q, fun_d;
  logic [31:0] a_q, a_d;     // op1 for MUL; dividend/quotient shift reg for DIV
  logic [31:0] b_q, b_d;     // op2 for MUL; divisor magnitude for DIV
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] res_q, res_d;

  logic        req_ready_w;
  logic        accept;
  logic        req_signed;
  logic        fast_hit;
  logic [31:0] fast_res;
  logic        mul_last;
  logic        div_last;
  logic [63:0] prod;
  logic [31:0] mul_hi;
  logic [31:0] mul_res;
  logic [31:0] step_rem, step_quo;
  logic [31:0] div_res;

  assign req_ready_w = (state_q == S_IDLE) && !flush;
  assign accept      = bus.req_valid && req_ready_w;
  assign mul_last    = (cnt_q == 5'(MUL_LAT - 1));
  assign div_last    = (cnt_q == 5'd31);

  // Decode of the incoming request, used only on the accept cycle.
  always_comb begin
    // NOTE: every signal driven from always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    req_signed = is_signed_div(bus.req_fun);
    fast_hit   = 1'b0;
    fast_res   = '0;
    if (ZERO_FASTPATH && is_div(bus.req_fun)) begin
      if (bus.req_op2 == '0) begin
        fast_hit = 1'b1;
        fast_res = is_rem(bus.req_fun) ? bus.req_op1 : 32'hFFFF_FFFF;
      end else if (req_signed && bus.req_op1 == 32'h8000_0000 &&
                   bus.req_op2 == 32'hFFFF_FFFF) begin
        fast_hit = 1'b1;
        fast_res = is_rem(bus.req_fun) ? 32'h0 : 32'h8000_0000;
      end
    end
  end

  // Unsigned product corrected into the signed high words.
  always_comb begin
    prod   = 64'(a_q) * 64'(b_q);
    mul_hi = prod[63:32];
    if (fun_q inside {ALU_MULH, ALU_MULHSU} && a_q[31]) mul_hi = mul_hi - b_q;
    if (fun_q == ALU_MULH && b_q[31])                   mul_hi = mul_hi - a_q;
    mul_res = (fun_q == ALU_MUL) ? prod[31:0] : mul_hi;
  end

  riscv32_div_step u_div_step (
    .rem_i (rem_q),
    .quo_i (a_q),
    .dvs_i (b_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign div_res = is_rem(fun_q) ? (neg_rem_q ? -step_rem : step_rem)
                                 : (neg_quo_q ? -step_quo : step_quo);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all datapath registers are reset too, so an aborted operation
      // can never leave a stale result on resp_data.
      state_q   <= S_IDLE;
      fun_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      fun_q     <= fun_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          if (is_mul(bus.req_fun))      state_d = S_MUL;
          else if (is_div(bus.req_fun)) state_d = fast_hit ? S_DONE : S_DIV;
          else                          state_d = S_DONE;
        end
        S_MUL:  if (mul_last) state_d = S_DONE;
        S_DIV:  if (div_last) state_d = S_DONE;
        S_DONE: if (bus.resp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    fun_d     = fun_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    if (!flush) begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          fun_d     = bus.req_fun;
          cnt_d     = '0;
          rem_d     = '0;
          a_d       = bus.req_op1;
          b_d       = bus.req_op2;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          res_d     = '0;
          if (is_div(bus.req_fun)) begin
            if (req_signed && bus.req_op1[31]) a_d = -bus.req_op1;
            if (req_signed && bus.req_op2[31]) b_d = -bus.req_op2;
            // Division by zero keeps the all-ones quotient unsigned.
            neg_quo_d = req_signed && (bus.req_op1[31] ^ bus.req_op2[31]) &&
                        (bus.req_op2 != '0);
            neg_rem_d = req_signed && bus.req_op1[31];
            if (fast_hit) res_d = fast_res;
          end
        end
        S_MUL: begin
          cnt_d = cnt_q + 5'd1;
          if (mul_last) res_d = mul_res;
        end
        S_DIV: begin
          a_d   = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + 5'd1;
          if (div_last) res_d = div_res;
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.req_ready  = req_ready_w;
    bus.resp_valid = (state_q == S_DONE);
    bus.resp_data  = res_q;
    busy           = (state_q != S_IDLE);
  end

endmodule
